// File: rtl/l2dr_arb.sv
// L2 / L2TLB to directory arbiter: two round-robin merge channels (req, disp)
// with one-entry output registers, plus a two-way snack router toward the sources.

typedef struct packed {
  logic [4:0]  nid;
  logic [3:0]  l2id;
  logic [2:0]  cmd;
  logic [31:0] paddr;
} I_l2todr_req_type;

typedef struct packed {
  logic [4:0]  nid;
  logic [3:0]  l2id;
  logic [5:0]  drid;
  logic [15:0] mask;
  logic [1:0]  dcmd;
  logic [63:0] line;
} I_l2todr_disp_type;

typedef struct packed {
  logic [4:0]  nid;
  logic [3:0]  l2id;
  logic [5:0]  drid;
  logic [4:0]  snack;
  logic [31:0] paddr;
} I_drtol2_snack_type;

module l2dr_arb #(
  parameter int unsigned NID_SEL = 0
) (
  input  logic               clk,
  input  logic               reset,

  input  logic               l2_req_valid,
  output logic               l2_req_retry,
  input  I_l2todr_req_type   l2_req,
  input  logic               tlb_req_valid,
  output logic               tlb_req_retry,
  input  I_l2todr_req_type   tlb_req,
  output logic               l2todr_req_valid,
  input  logic               l2todr_req_retry,
  output I_l2todr_req_type   l2todr_req,

  input  logic               l2_disp_valid,
  output logic               l2_disp_retry,
  input  I_l2todr_disp_type  l2_disp,
  input  logic               tlb_disp_valid,
  output logic               tlb_disp_retry,
  input  I_l2todr_disp_type  tlb_disp,
  output logic               l2todr_disp_valid,
  input  logic               l2todr_disp_retry,
  output I_l2todr_disp_type  l2todr_disp,

  input  logic               drtol2_snack_valid,
  output logic               drtol2_snack_retry,
  input  I_drtol2_snack_type drtol2_snack,
  output logic               snack_l2_valid,
  input  logic               snack_l2_retry,
  output I_drtol2_snack_type snack_l2_data,
  output logic               snack_tlb_valid,
  input  logic               snack_tlb_retry,
  output I_drtol2_snack_type snack_tlb_data
);

  // bit 0 = grant source a (L2), bit 1 = grant source b (L2TLB)
  function automatic logic [1:0] rr_grant(input logic can, input logic av,
                                          input logic bv, input logic ptr);
    rr_grant[0] = can && av && (!bv || !ptr);
    rr_grant[1] = can && bv && (!av || ptr);
  endfunction

  logic             rq_full_q, rq_full_d, rq_ptr_q, rq_ptr_d, rq_ga, rq_gb;
  I_l2todr_req_type rq_data_q, rq_data_d;

  always_comb begin
    {rq_gb, rq_ga} = rr_grant(!reset && (!rq_full_q || !l2todr_req_retry),
                              l2_req_valid, tlb_req_valid, rq_ptr_q);
    l2_req_retry  = !rq_ga;
    tlb_req_retry = !rq_gb;
    rq_full_d     = (rq_full_q && l2todr_req_retry) || rq_ga || rq_gb;
    rq_ptr_d      = rq_ptr_q;
    rq_data_d     = rq_data_q;
    if (rq_ga) begin
      rq_ptr_d               = 1'b1;
      rq_data_d              = l2_req;
      rq_data_d.nid[NID_SEL] = 1'b0;
    end else if (rq_gb) begin
      rq_ptr_d               = 1'b0;
      rq_data_d              = tlb_req;
      rq_data_d.nid[NID_SEL] = 1'b1;
    end
  end

  logic              dp_full_q, dp_full_d, dp_ptr_q, dp_ptr_d, dp_ga, dp_gb;
  I_l2todr_disp_type dp_data_q, dp_data_d;

  always_comb begin
    {dp_gb, dp_ga} = rr_grant(!reset && (!dp_full_q || !l2todr_disp_retry),
                              l2_disp_valid, tlb_disp_valid, dp_ptr_q);
    l2_disp_retry  = !dp_ga;
    tlb_disp_retry = !dp_gb;
    dp_full_d      = (dp_full_q && l2todr_disp_retry) || dp_ga || dp_gb;
    dp_ptr_d       = dp_ptr_q;
    dp_data_d      = dp_data_q;
    if (dp_ga) begin
      dp_ptr_d               = 1'b1;
      dp_data_d              = l2_disp;
      dp_data_d.nid[NID_SEL] = 1'b0;
    end else if (dp_gb) begin
      dp_ptr_d               = 1'b0;
      dp_data_d              = tlb_disp;
      dp_data_d.nid[NID_SEL] = 1'b1;
    end
  end

  logic               sn_sel, sn_acc;
  logic               sl2_full_q, sl2_full_d, stl_full_q, stl_full_d;
  I_drtol2_snack_type sl2_data_q, sl2_data_d, stl_data_q, stl_data_d;

  // Input retry looks only at the destination it steers to, so a stalled
  // path never blocks snacks headed for the other one.
  always_comb begin
    sn_sel             = drtol2_snack.nid[NID_SEL];
    drtol2_snack_retry = reset || (sn_sel ? (stl_full_q && snack_tlb_retry)
                                          : (sl2_full_q && snack_l2_retry));
    sn_acc             = drtol2_snack_valid && !drtol2_snack_retry;
    sl2_full_d         = (sl2_full_q && snack_l2_retry)  || (sn_acc && !sn_sel);
    stl_full_d         = (stl_full_q && snack_tlb_retry) || (sn_acc &&  sn_sel);
    sl2_data_d         = (sn_acc && !sn_sel) ? drtol2_snack : sl2_data_q;
    stl_data_d         = (sn_acc &&  sn_sel) ? drtol2_snack : stl_data_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rq_full_q  <= 1'b0;
      rq_ptr_q   <= 1'b0;
      dp_full_q  <= 1'b0;
      dp_ptr_q   <= 1'b0;
      sl2_full_q <= 1'b0;
      stl_full_q <= 1'b0;
    end else begin
      rq_full_q  <= rq_full_d;
      rq_ptr_q   <= rq_ptr_d;
      dp_full_q  <= dp_full_d;
      dp_ptr_q   <= dp_ptr_d;
      sl2_full_q <= sl2_full_d;
      stl_full_q <= stl_full_d;
    end
    rq_data_q  <= rq_data_d;
    dp_data_q  <= dp_data_d;
    sl2_data_q <= sl2_data_d;
    stl_data_q <= stl_data_d;
  end

  assign l2todr_req_valid  = rq_full_q && !reset;
  assign l2todr_req        = rq_data_q;
  assign l2todr_disp_valid = dp_full_q && !reset;
  assign l2todr_disp       = dp_data_q;
  assign snack_l2_valid    = sl2_full_q && !reset;
  assign snack_l2_data     = sl2_data_q;
  assign snack_tlb_valid   = stl_full_q && !reset;
  assign snack_tlb_data    = stl_data_q;

endmodule
